// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, index/data typedefs and packing helper for the register file.
package regfile_pkg;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_AW       = $clog2(DEF_NUM_REGS);
  typedef logic [DEF_AW-1:0]   reg_idx_t;
  typedef logic [DEF_XLEN-1:0] reg_data_t;
  function automatic int src_lsb(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-producer bits, pending count and per-port busy flags.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_WriteEnable,
  input  logic [AW-1:0]          i_RegDest,
  input  logic                   i_IssueValid,
  input  logic [AW-1:0]          i_IssueDest,
  input  logic [NUM_READ*AW-1:0] i_RegSource,
  output logic [NUM_READ-1:0]    o_SourceBusy,
  output logic [AW:0]            o_BusyCount
);
  logic [NUM_REGS-1:0] r_busy;
  logic [AW:0]         r_count;
  logic                w_set, w_clr, w_same, w_inc, w_dec;
  assign w_set  = i_IssueValid && i_IssueDest != '0;
  assign w_clr  = i_WriteEnable && i_RegDest != '0;
  assign w_same = w_set && i_IssueDest == i_RegDest;
  assign w_inc  = w_set && !r_busy[i_IssueDest];
  // a write racing an issue to the same register keeps it pending, so no decrement
  assign w_dec  = w_clr && !w_same && r_busy[i_RegDest];
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++)
        r_busy[r] <= (w_set && i_IssueDest == AW'(r)) ? 1'b1 :
                     (w_clr && i_RegDest == AW'(r)) ? 1'b0 : r_busy[r];
      r_count <= r_count + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end
  assign o_BusyCount = r_count;
  for (genvar k = 0; k < NUM_READ; k++) begin : g_src
    logic [AW-1:0] w_src;
    assign w_src = i_RegSource[src_lsb(k, AW) +: AW];
    assign o_SourceBusy[k] = (BYPASS != 0 && w_clr && !w_same && w_src == i_RegDest) ? 1'b0 : r_busy[w_src];
  end
endmodule

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: multi-port register file with optional write bypass and a pending-producer scoreboard.
module register_file_scoreboard import regfile_pkg::*; #(
  parameter int XLEN     = DEF_XLEN,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_WriteEnable,
  input  logic [AW-1:0]            i_RegDest,
  input  logic [XLEN-1:0]          i_DataIn,
  input  logic [NUM_READ*AW-1:0]   i_RegSource,
  output logic [NUM_READ*XLEN-1:0] o_DataOut,
  output logic [NUM_READ-1:0]      o_SourceBusy,
  input  logic                     i_IssueValid,
  input  logic [AW-1:0]            i_IssueDest,
  output logic [AW:0]              o_BusyCount
);
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_wr;
  assign w_wr = i_WriteEnable && i_RegDest != '0;
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else if (w_wr) begin
      r_regs[i_RegDest] <= i_DataIn;
    end
  end
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] w_src;
    assign w_src = i_RegSource[src_lsb(k, AW) +: AW];
    assign o_DataOut[src_lsb(k, XLEN) +: XLEN] = (w_src == '0) ? '0 :
      (BYPASS != 0 && w_wr && w_src == i_RegDest) ? i_DataIn : r_regs[w_src];
  end
  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_READ(NUM_READ), .BYPASS(BYPASS)) u_sb (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .i_WriteEnable(i_WriteEnable),
    .i_RegDest    (i_RegDest),
    .i_IssueValid (i_IssueValid),
    .i_IssueDest  (i_IssueDest),
    .i_RegSource  (i_RegSource),
    .o_SourceBusy (o_SourceBusy),
    .o_BusyCount  (o_BusyCount)
  );
endmodule
